mn_rle_packer: RTL and testbench



---
 rtl/mn_rle_packer.sv | 173 +++++++++++++++++
 tb/tb_mn_rle_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mn_rle_packer.sv
// mn_rle_packer
//   Run-length packer for the 2-bit (m,n) symbol stream of the Mealy control
//   FSM. Runs of identical symbols are closed into {symbol, length} packets
//   that are queued in a first-word-fall-through FIFO behind a valid/ready
//   output handshake.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   symbol {m,n} is sampled this cycle
//   m, n       symbol bits (m is the MSB)
//   flush      close the current run and queue it as a packet
//   out_valid  FIFO head packet available
//   out_ready  consumer accepts the head packet
//   out_sym    head packet symbol, 0 when empty
//   out_len    head packet run length, 0 when empty
//   overflow   sticky: a packet was dropped because the FIFO was full
//   pkt_count  (MN_RLE_STATS_EN only) saturating count of accepted packets
//
// Build option
//   MN_RLE_STATS_EN  adds the pkt_count output and its counter.
//
// Run FSM
//   state  | meaning
//   S_IDLE | no open run; flush is ignored
//   S_RUN  | run of cur_sym with run_len >= 1 in progress

module mn_rle_packer #(
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             m,
    input  logic             n,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sym,
    output logic [CNT_W-1:0] out_len,
    output logic             overflow
`ifdef MN_RLE_STATS_EN
    ,
    output logic [15:0]      pkt_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = {CNT_W{1'b1}};
    localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       cur_sym, cur_sym_nx;
    logic [CNT_W-1:0] run_len, run_len_nx;
    logic [1:0]       sym;

    logic             push;
    logic [1:0]       push_sym;
    logic [CNT_W-1:0] push_len;

    logic [1:0]       mem_sym [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_len [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, pop, wr_en, drop;

    assign sym = {m, n};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cur_sym <= '0;
            run_len <= '0;
        end else begin
            state   <= state_nx;
            cur_sym <= cur_sym_nx;
            run_len <= run_len_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cur_sym_nx = cur_sym;
        run_len_nx = run_len;
        push       = 1'b0;
        push_sym   = cur_sym;
        push_len   = run_len;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx   = S_RUN;
                    cur_sym_nx = sym;
                    run_len_nx = CNT_W'(1);
                end
            end
            S_RUN: begin
                if (flush) begin
                    // A same-cycle symbol opens a fresh run, never joins the flushed one.
                    push = 1'b1;
                    if (in_valid) begin
                        cur_sym_nx = sym;
                        run_len_nx = CNT_W'(1);
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else if (in_valid) begin
                    if (sym == cur_sym && run_len != MAX_LEN) begin
                        run_len_nx = run_len + CNT_W'(1);
                    end else begin
                        // Symbol change, or a saturated run restarting with the same symbol.
                        push       = 1'b1;
                        cur_sym_nx = sym;
                        run_len_nx = CNT_W'(1);
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    assign out_sym = out_valid ? mem_sym[rd_ptr] : 2'b00;
    assign out_len = out_valid ? mem_len[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_sym[wr_ptr] <= push_sym;
            mem_len[wr_ptr] <= push_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef MN_RLE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (pop && pkt_count != 16'hFFFF) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mn_rle_packer.sv
// Testbench for mn_rle_packer: table of directed vectors with hand-computed
// expected outputs, plus hand-written sequences for the stall and statistics
// cases.

module tb_mn_rle_packer;

    logic       clk = 1'b0;
    logic       rst, in_valid, m, n, flush, out_ready;
    logic       out_valid, overflow;
    logic [1:0] out_sym;
    logic [3:0] out_len;
`ifdef MN_RLE_STATS_EN
    logic [15:0] pkt_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mn_rle_packer #(.CNT_W(4), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .m         (m),
        .n         (n),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_len   (out_len),
        .overflow  (overflow)
`ifdef MN_RLE_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    typedef struct {
        logic       r;
        logic       iv;
        logic [1:0] s;
        logic       fl;
        logic       rdy;
        logic       ev;
        logic [1:0] es;
        logic [3:0] el;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic iv, input logic [1:0] s,
                       input logic fl, input logic rdy, input logic ev,
                       input logic [1:0] es, input logic [3:0] el, input logic eo);
        vec_t v;
        v.r = r; v.iv = iv; v.s = s; v.fl = fl; v.rdy = rdy;
        v.ev = ev; v.es = es; v.el = el; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] s,
                         input logic fl, input logic rdy);
        rst = r; in_valid = iv; m = s[1]; n = s[0]; flush = fl; out_ready = rdy;
    endtask

    // Drive, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic iv, input logic [1:0] s,
                        input logic fl, input logic rdy);
        drive(r, iv, s, fl, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic ev, input logic [1:0] es,
                             input logic [3:0] el, input logic eo);
        checks++;
        if (out_valid !== ev || out_sym !== es || out_len !== el || overflow !== eo) begin
            errors++;
            $display("FAIL %s: got v=%b sym=%b len=%0d ovf=%b, want v=%b sym=%b len=%0d ovf=%b",
                     name, out_valid, out_sym, out_len, overflow, ev, es, el, eo);
        end
    endtask

    initial begin
        // ---- reset, run of 00 x3 closed by 01 ----
        add(1,0,2'b00,0,1, 0,2'b00,4'd0,0);
        add(0,1,2'b00,0,1, 0,2'b00,4'd0,0);
        add(0,1,2'b00,0,1, 0,2'b00,4'd0,0);
        add(0,1,2'b00,0,1, 0,2'b00,4'd0,0);
        add(0,1,2'b01,0,1, 1,2'b00,4'd3,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);
        add(0,0,2'b00,1,1, 1,2'b01,4'd1,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);
        // ---- 17 x 11 then flush: {11,15} then {11,2} ----
        add(1,0,2'b00,0,0, 0,2'b00,4'd0,0);
        for (int i = 0; i < 15; i++) add(0,1,2'b11,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b11,0,0, 1,2'b11,4'd15,0);
        add(0,1,2'b11,0,0, 1,2'b11,4'd15,0);
        add(0,0,2'b00,1,0, 1,2'b11,4'd15,0);
        add(0,0,2'b00,0,1, 1,2'b11,4'd2,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);
        // ---- overflow: 5 pushes into a 4-deep FIFO ----
        add(1,0,2'b00,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b01,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b10,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b01,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b10,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b01,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b10,0,0, 1,2'b01,4'd1,1);
        add(0,0,2'b00,0,1, 1,2'b10,4'd1,1);
        add(0,0,2'b00,0,1, 1,2'b01,4'd1,1);
        add(0,0,2'b00,0,1, 1,2'b10,4'd1,1);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,1);
        // ---- flush with same-cycle symbol, flush, flush in IDLE ----
        add(1,0,2'b00,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b10,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b10,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b00,1,0, 1,2'b10,4'd2,0);
        add(0,0,2'b00,1,0, 1,2'b10,4'd2,0);
        add(0,0,2'b00,1,0, 1,2'b10,4'd2,0);
        add(0,0,2'b00,0,1, 1,2'b00,4'd1,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);
        // ---- reset mid-run with 2 packets queued ----
        add(1,0,2'b00,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b00,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b01,0,0, 1,2'b00,4'd1,0);
        add(0,1,2'b10,0,0, 1,2'b00,4'd1,0);
        add(1,1,2'b11,1,1, 0,2'b00,4'd0,0);
        add(0,0,2'b00,1,0, 0,2'b00,4'd0,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);
        // ---- push and pop together while full ----
        add(1,0,2'b00,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b01,0,0, 0,2'b00,4'd0,0);
        add(0,1,2'b10,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b01,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b10,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b01,0,0, 1,2'b01,4'd1,0);
        add(0,1,2'b10,0,1, 1,2'b10,4'd1,0);
        add(0,0,2'b00,0,1, 1,2'b01,4'd1,0);
        add(0,0,2'b00,0,1, 1,2'b10,4'd1,0);
        add(0,0,2'b00,0,1, 1,2'b01,4'd1,0);
        add(0,0,2'b00,0,1, 0,2'b00,4'd0,0);

        drive(1, 0, 2'b00, 0, 0);
        #2;
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].s, tbl[i].fl, tbl[i].rdy);
            check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].el, tbl[i].eo);
        end

        // ---- stall: head must hold while out_ready=0 ----
        step(1, 0, 2'b00, 0, 0);
        step(0, 1, 2'b11, 0, 0);
        step(0, 1, 2'b11, 0, 0);
        step(0, 1, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 2'b00, 0, 0);
            check_out($sformatf("stall%0d", k), 1'b1, 2'b11, 4'd2, 1'b0);
        end

        // ---- bounded wait for the packet closed by a flush ----
        step(0, 0, 2'b00, 0, 1);
        step(0, 0, 2'b00, 1, 0);
        begin
            int budget;
            budget = 0;
            while (!(out_valid && out_sym == 2'b00) && budget < 8) begin
                step(0, 0, 2'b00, 0, 0);
                budget++;
            end
            checks++;
            if (budget >= 8) begin
                errors++;
                $display("FAIL flush_wait: no packet {00,1} within 8 cycles (v=%b sym=%b)",
                         out_valid, out_sym);
            end else begin
                check_out("flush_pkt", 1'b1, 2'b00, 4'd1, 1'b0);
            end
        end

`ifdef MN_RLE_STATS_EN
        // ---- packet counter: 3 accepted, one stalled cycle ----
        step(1, 0, 2'b00, 0, 0);
        step(0, 1, 2'b00, 0, 0);
        step(0, 1, 2'b01, 0, 0);
        step(0, 1, 2'b10, 0, 0);
        step(0, 1, 2'b11, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 2'b00, 0, 1);
        checks++;
        if (pkt_count !== 16'd3) begin
            errors++;
            $display("FAIL pkt_count: got %0d want 3", pkt_count);
        end
        step(1, 0, 2'b00, 0, 0);
        checks++;
        if (pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL pkt_count_rst: got %0d want 0", pkt_count);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
